// File: rtl/sram_req_sequencer.sv
// Queues host commands and issues them one at a time to the SRAM controller; issue 2 cycles after accept into empty FIFO.
// Host backpressure via s_ready (FIFO full); responses are single-cycle pulses with no backpressure.
module sram_req_sequencer #(
    parameter int ADDR_W  = 21,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic                    s_we,
    input  logic [ADDR_W-1:0]       s_addr,
    input  logic [DATA_W-1:0]       s_wdata,
    output logic                    r_valid,
    output logic                    r_is_wr,
    output logic                    r_err,
    output logic [DATA_W-1:0]       r_data,
    output logic [$clog2(DEPTH):0]  o_level,
    output logic                    o_idle,
    output logic                    o_rd_strt,
    output logic                    o_wr_strt,
    output logic [ADDR_W-1:0]       o_address,
    output logic [DATA_W-1:0]       o_data,
    input  logic                    i_busy,
    input  logic                    i_data_valid,
    input  logic [DATA_W-1:0]       i_rdata,
    input  logic                    i_wr_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    cmd_t             mem [DEPTH];
    cmd_t             cmd_in;
    cmd_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nxt;
    logic             op_we;
    logic             done_q;
    logic             err_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0] tmo_cnt;
    logic             done_now;
    logic             complete;
    logic             tmo_hit;

    assign cmd_in  = '{we: s_we, addr: s_addr, wdata: s_wdata};
    assign head    = mem[rd_ptr];
    assign s_ready = (level != FULL_LVL);
    assign push    = s_valid && s_ready;
    assign pop     = (state == ST_IDLE) && (level != '0);
    assign o_level = level;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // A completion pulse only counts if it matches the operation in flight.
    assign done_now = op_we ? i_wr_done : i_data_valid;
    assign complete = (done_q || done_now) && !i_busy;
    assign tmo_hit  = !complete && (tmo_cnt == LAST_CNT);

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (level != '0) state_nxt = ST_ISSUE;
            ST_ISSUE: if (i_busy) state_nxt = ST_WAIT;
            ST_WAIT:  if (complete || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            op_we     <= 1'b0;
            o_address <= '0;
            o_data    <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            if (pop) begin
                op_we     <= head.we;
                o_address <= head.addr;
                o_data    <= head.wdata;
                rdata_q   <= '0;
                done_q    <= 1'b0;
                err_q     <= 1'b0;
            end
            if (state == ST_ISSUE) begin
                tmo_cnt <= '0;
            end
            if (state == ST_WAIT) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
                if (done_now) begin
                    done_q <= 1'b1;
                end
                if (!op_we && i_data_valid) begin
                    rdata_q <= i_rdata;
                end
                if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // Strobes are pure state decodes so they drop on the same edge that enters WAIT.
    assign o_rd_strt = (state == ST_ISSUE) && !op_we;
    assign o_wr_strt = (state == ST_ISSUE) && op_we;
    assign o_idle    = (state == ST_IDLE) && (level == '0);
    assign r_valid   = (state == ST_RESP);
    assign r_is_wr   = r_valid && op_we;
    assign r_err     = r_valid && err_q;
    assign r_data    = (r_valid && !op_we && !err_q) ? rdata_q : '0;

endmodule

// File: tb/tb_sram_req_sequencer.sv
// Scoreboarded bench: expected issues and responses are queued at stimulus time, a controller model and a response monitor check them.
module tb_sram_req_sequencer;

    logic        i_clk;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic        s_we;
    logic [20:0] s_addr;
    logic [15:0] s_wdata;
    logic        r_valid;
    logic        r_is_wr;
    logic        r_err;
    logic [15:0] r_data;
    logic [2:0]  o_level;
    logic        o_idle;
    logic        o_rd_strt;
    logic        o_wr_strt;
    logic [20:0] o_address;
    logic [15:0] o_data;
    logic        i_busy;
    logic        i_data_valid;
    logic [15:0] i_rdata;
    logic        i_wr_done;

    sram_req_sequencer dut (
        .i_clk        (i_clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_we         (s_we),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .r_valid      (r_valid),
        .r_is_wr      (r_is_wr),
        .r_err        (r_err),
        .r_data       (r_data),
        .o_level      (o_level),
        .o_idle       (o_idle),
        .o_rd_strt    (o_rd_strt),
        .o_wr_strt    (o_wr_strt),
        .o_address    (o_address),
        .o_data       (o_data),
        .i_busy       (i_busy),
        .i_data_valid (i_data_valid),
        .i_rdata      (i_rdata),
        .i_wr_done    (i_wr_done)
    );

    typedef struct packed {
        logic        we;
        logic [20:0] addr;
        logic [15:0] data;
    } iss_t;

    typedef struct packed {
        logic        is_wr;
        logic        err;
        logic [15:0] data;
    } resp_t;

    iss_t  iss_q[$];
    resp_t resp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Controller model knobs
    logic  stall = 1'b0;
    logic  hang  = 1'b0;
    logic  same  = 1'b0;
    logic  wrong = 1'b0;
    int    dly   = 5;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rd_data_of(input logic [20:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return (a == 21'h00010) ? 16'hBEEF : (lo ^ 16'hC3C3);
    endfunction

    // Controller model: checks each issued command against the issue scoreboard.
    initial begin
        logic        m_we;
        logic [20:0] m_addr;
        iss_t        e;
        i_busy = 1'b0;
        i_data_valid = 1'b0;
        i_wr_done = 1'b0;
        i_rdata = '0;
        forever begin
            @(negedge i_clk);
            if (!reset) begin
                i_busy = 1'b0;
                i_data_valid = 1'b0;
                i_wr_done = 1'b0;
                continue;
            end
            if (!stall && !i_busy && (o_rd_strt || o_wr_strt)) begin
                chk("single_strobe", {31'd0, o_rd_strt & o_wr_strt}, 32'd0);
                if (iss_q.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    e = iss_q.pop_front();
                    chk("issue_we", {31'd0, o_wr_strt}, {31'd0, e.we});
                    chk("issue_addr", {11'd0, o_address}, {11'd0, e.addr});
                    if (e.we) chk("issue_data", {16'd0, o_data}, {16'd0, e.data});
                end
                m_we = o_wr_strt;
                m_addr = o_address;
                i_busy = 1'b1;
                if (hang) begin
                    for (int k = 0; k < 600; k++) begin
                        @(negedge i_clk);
                        if (r_valid || !reset) break;
                    end
                    i_busy = 1'b0;
                end else begin
                    repeat (dly) @(negedge i_clk);
                    if (wrong) begin
                        if (m_we) i_data_valid = 1'b1;
                        else      i_wr_done = 1'b1;
                        i_rdata = 16'hDEAD;
                        i_busy = 1'b0;
                        @(negedge i_clk);
                        i_data_valid = 1'b0;
                        i_wr_done = 1'b0;
                    end
                    if (m_we) begin
                        i_wr_done = 1'b1;
                    end else begin
                        i_data_valid = 1'b1;
                        i_rdata = rd_data_of(m_addr);
                    end
                    if (same || wrong) i_busy = 1'b0;
                    @(negedge i_clk);
                    i_wr_done = 1'b0;
                    i_data_valid = 1'b0;
                    i_busy = 1'b0;
                end
            end
        end
    end

    // Response monitor
    initial begin
        resp_t e;
        forever begin
            @(negedge i_clk);
            if (reset && r_valid) begin
                if (resp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    chk("resp_is_wr", {31'd0, r_is_wr}, {31'd0, e.is_wr});
                    chk("resp_err", {31'd0, r_err}, {31'd0, e.err});
                    chk("resp_data", {16'd0, r_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic push(input logic we, input logic [20:0] addr, input logic [15:0] wdata);
        int n;
        @(negedge i_clk);
        s_valid = 1'b1;
        s_we = we;
        s_addr = addr;
        s_wdata = wdata;
        n = 0;
        while (!s_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (!s_ready) chk("push_ready_wait", 32'd0, 32'd1);
        @(posedge i_clk);
        #1 s_valid = 1'b0;
    endtask

    task automatic cmd(input logic we, input logic [20:0] addr, input logic [15:0] wdata,
                       input logic err, input logic [15:0] rdata);
        iss_q.push_back('{we: we, addr: addr, data: wdata});
        resp_q.push_back('{is_wr: we, err: err, data: rdata});
        push(we, addr, wdata);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!(resp_q.size() == 0 && o_idle) && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        chk(name, {31'd0, (resp_q.size() == 0) && o_idle}, 32'd1);
    endtask

    initial begin
        int elapsed;
        reset = 1'b0;
        s_valid = 1'b0;
        s_we = 1'b0;
        s_addr = '0;
        s_wdata = '0;
        repeat (3) @(negedge i_clk);
        reset = 1'b1;
        @(negedge i_clk);

        // Post-reset state
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_o_idle", {31'd0, o_idle}, 32'd1);
        chk("rst_strobes", {30'd0, o_rd_strt, o_wr_strt}, 32'd0);
        chk("rst_level", {29'd0, o_level}, 32'd0);
        chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_addr_data", {o_address[15:0], o_data}, 32'd0);

        // Single write with issue latency check
        dly = 5;
        cmd(1'b1, 21'h1ABCD, 16'h5A5A, 1'b0, 16'h0000);
        @(negedge i_clk);
        chk("lat_level_1", {29'd0, o_level}, 32'd1);
        chk("lat_no_strobe_yet", {31'd0, o_wr_strt}, 32'd0);
        chk("lat_not_idle", {31'd0, o_idle}, 32'd0);
        @(negedge i_clk);
        chk("lat_wr_strobe", {31'd0, o_wr_strt}, 32'd1);
        chk("lat_level_0", {29'd0, o_level}, 32'd0);
        drain("drain_write");

        // Plain read
        dly = 3;
        cmd(1'b0, 21'h00010, 16'h0000, 1'b0, 16'hBEEF);
        drain("drain_read");

        // Write with done and busy-low in the same cycle
        same = 1'b1;
        cmd(1'b1, 21'h00123, 16'h1234, 1'b0, 16'h0000);
        drain("drain_same_cycle");
        same = 1'b0;

        // Read preceded by a wrong-type done pulse
        wrong = 1'b1;
        cmd(1'b0, 21'h00200, 16'h0000, 1'b0, 16'hC1C3);
        drain("drain_wrong_op");
        wrong = 1'b0;

        // Fill the FIFO while the controller is powering up
        stall = 1'b1;
        dly = 2;
        cmd(1'b1, 21'h00100, 16'h1111, 1'b0, 16'h0000);
        cmd(1'b0, 21'h00101, 16'h0000, 1'b0, 16'hC2C2);
        cmd(1'b1, 21'h00102, 16'h2222, 1'b0, 16'h0000);
        cmd(1'b0, 21'h00103, 16'h0000, 1'b0, 16'hC2C0);
        cmd(1'b1, 21'h1FFFF, 16'hFFFF, 1'b0, 16'h0000);
        @(negedge i_clk);
        chk("full_level", {29'd0, o_level}, 32'd4);
        chk("full_s_ready", {31'd0, s_ready}, 32'd0);
        s_valid = 1'b1;
        s_we = 1'b0;
        s_addr = 21'h0DEAD;
        repeat (3) @(negedge i_clk);
        s_valid = 1'b0;
        chk("full_no_push", {29'd0, o_level}, 32'd4);
        repeat (20) @(negedge i_clk);
        chk("stall_strobe_held", {31'd0, o_wr_strt}, 32'd1);
        chk("stall_addr_stable", {11'd0, o_address}, 32'h00100);
        @(posedge i_clk);
        #1 stall = 1'b0;
        drain("drain_burst");

        // Timeout, then a normal command
        hang = 1'b1;
        cmd(1'b0, 21'h00055, 16'h0000, 1'b1, 16'h0000);
        elapsed = 0;
        while (!o_rd_strt && elapsed < 50) begin
            @(negedge i_clk);
            elapsed++;
        end
        elapsed = 0;
        while (!r_valid && elapsed < 600) begin
            @(negedge i_clk);
            elapsed++;
        end
        chk("timeout_cycles", elapsed, 32'd256);
        drain("drain_timeout");
        hang = 1'b0;
        dly = 2;
        cmd(1'b1, 21'h00077, 16'h7777, 1'b0, 16'h0000);
        drain("drain_after_timeout");

        // Reset while in WAIT with two queued commands
        hang = 1'b1;
        iss_q.push_back('{we: 1'b1, addr: 21'h00AAA, data: 16'hAAAA});
        push(1'b1, 21'h00AAA, 16'hAAAA);
        push(1'b0, 21'h00BBB, 16'h0000);
        push(1'b1, 21'h00CCC, 16'hCCCC);
        repeat (5) @(negedge i_clk);
        chk("mid_level", {29'd0, o_level}, 32'd2);
        chk("mid_busy", {31'd0, i_busy}, 32'd1);
        reset = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_level", {29'd0, o_level}, 32'd0);
        chk("mid_rst_ready_idle", {30'd0, s_ready, o_idle}, 32'd3);
        chk("mid_rst_strobes", {30'd0, o_rd_strt, o_wr_strt}, 32'd0);
        chk("mid_rst_r_valid", {31'd0, r_valid}, 32'd0);
        chk("mid_rst_addr", {11'd0, o_address}, 32'd0);
        chk("mid_rst_data", {16'd0, o_data}, 32'd0);
        @(negedge i_clk);
        reset = 1'b1;
        hang = 1'b0;
        repeat (20) @(negedge i_clk);
        chk("post_rst_idle", {31'd0, o_idle}, 32'd1);
        chk("post_rst_level", {29'd0, o_level}, 32'd0);
        chk("iss_q_empty", iss_q.size(), 32'd0);
        chk("resp_q_empty", resp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
